// File: rtl/mipi_check_pkg.sv
// Shared types and CRC helper for the MIPI CSI-2 frame-geometry checker.
// The CRC helper is only referenced when MIPI_FRAME_CHECK_CRC_EN is defined.
package mipi_check_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SYNC      = 2'd1,
        ACTIVE    = 2'd2
    } state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // CRC-16-CCITT over the low 'width' bits of data, MSB first.
    function automatic logic [15:0] crc16_next(input logic [15:0]   crc,
                                               input logic [63:0]   data,
                                               input int unsigned   width);
        logic [15:0] c;
        logic [63:0] d;
        logic        fb;
        c = crc;
        d = data << (64 - width);
        for (int unsigned i = 0; i < width; i++) begin
            fb = c[15] ^ d[63];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
            d  = d << 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/mipi_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module mipi_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mipi_frame_check.sv
// Frame-geometry checker for the unpacked CSI-2 raw pixel stream (rows/frame, words/row).
// Optional frame CRC output enabled by defining MIPI_FRAME_CHECK_CRC_EN.
module mipi_frame_check
    import mipi_check_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned H_WORDS = 960,
    parameter int unsigned V_ROWS  = 1080,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned FRM_W   = 16
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              raw_vld,
    input  logic [DATA_W-1:0] raw_data,
    input  logic              raw_vsync,
    input  logic              err_clr,
    output logic [FRM_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  last_rows,
    output logic [CNT_W-1:0]  last_words,
    output logic              row_err,
    output logic              col_err,
    output logic              frame_ok,
    output logic [ERR_W-1:0]  row_err_cnt,
    output logic [ERR_W-1:0]  col_err_cnt,
    output logic              err_sticky
`ifdef MIPI_FRAME_CHECK_CRC_EN
    ,
    output logic [15:0]       frame_crc
`endif
);

    state_e            state_q, state_d;
    logic              vld_r1_q, vsync_r1_q;
    logic              in_row_q, in_row_d;
    logic              col_seen_q, col_seen_d;
    logic              row_err_q, row_err_d;
    logic              col_err_q, col_err_d;
    logic              frame_ok_q, frame_ok_d;
    logic              sticky_q, sticky_d;
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  last_rows_q, last_rows_d;
    logic [CNT_W-1:0]  last_words_q, last_words_d;
    logic [CNT_W-1:0]  row_cnt, word_cnt;

    logic vld_rise, vld_fall, vs_rise;
    logic in_active, frame_end, row_start, row_close, row_active;

    assign vld_rise = raw_vld & ~vld_r1_q;
    assign vld_fall = ~raw_vld & vld_r1_q;
    assign vs_rise  = raw_vsync & ~vsync_r1_q;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q <= WAIT_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SYNC: if (vs_rise)    state_d = SYNC;
            SYNC:      if (!raw_vsync) state_d = ACTIVE;
            ACTIVE:    if (vs_rise)    state_d = SYNC;
            default:                   state_d = WAIT_SYNC;
        endcase
    end

    // A row is only tracked if its vld_rise is seen in ACTIVE and does not coincide with vs_rise.
    always_comb begin
        in_active = (state_q == ACTIVE);
        frame_end = in_active & vs_rise;
        row_start = in_active & vld_rise & ~vs_rise;
        row_close = in_active & in_row_q & (vld_fall | vs_rise);
    end

    assign row_active = in_row_q | row_start;

    // Word counter is kept at 0 outside a row so the first word of a row counts as 1.
    mipi_sat_cnt #(.W(CNT_W)) u_word_cnt (
        .clk_i (sclk),
        .rst_i (s_rst),
        .clr_i (~row_active | row_close),
        .inc_i (raw_vld & row_active),
        .cnt_o (word_cnt)
    );

    mipi_sat_cnt #(.W(CNT_W)) u_row_cnt (
        .clk_i (sclk),
        .rst_i (s_rst),
        .clr_i (~in_active),
        .inc_i (row_start),
        .cnt_o (row_cnt)
    );

    mipi_sat_cnt #(.W(ERR_W)) u_row_err_cnt (
        .clk_i (sclk),
        .rst_i (s_rst),
        .clr_i (err_clr),
        .inc_i (row_err_q),
        .cnt_o (row_err_cnt)
    );

    mipi_sat_cnt #(.W(ERR_W)) u_col_err_cnt (
        .clk_i (sclk),
        .rst_i (s_rst),
        .clr_i (err_clr),
        .inc_i (col_err_q),
        .cnt_o (col_err_cnt)
    );

    always_comb begin
        in_row_d     = in_active & ((in_row_q & ~row_close) | row_start);
        col_err_d    = row_close & (word_cnt != CNT_W'(H_WORDS));
        row_err_d    = frame_end & (row_cnt != CNT_W'(V_ROWS));
        frame_ok_d   = frame_end & ~row_err_d & ~col_err_d & ~col_seen_q;
        col_seen_d   = in_active & ~frame_end & (col_seen_q | col_err_d);
        last_words_d = row_close ? word_cnt : last_words_q;
        last_rows_d  = frame_end ? row_cnt : last_rows_q;
        frame_cnt_d  = frame_end ? frame_cnt_q + FRM_W'(1) : frame_cnt_q;
        sticky_d     = err_clr ? 1'b0 : (sticky_q | row_err_q | col_err_q);
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            vld_r1_q     <= 1'b0;
            vsync_r1_q   <= 1'b0;
            in_row_q     <= 1'b0;
            col_seen_q   <= 1'b0;
            row_err_q    <= 1'b0;
            col_err_q    <= 1'b0;
            frame_ok_q   <= 1'b0;
            sticky_q     <= 1'b0;
            frame_cnt_q  <= '0;
            last_rows_q  <= '0;
            last_words_q <= '0;
        end else begin
            vld_r1_q     <= raw_vld;
            vsync_r1_q   <= raw_vsync;
            in_row_q     <= in_row_d;
            col_seen_q   <= col_seen_d;
            row_err_q    <= row_err_d;
            col_err_q    <= col_err_d;
            frame_ok_q   <= frame_ok_d;
            sticky_q     <= sticky_d;
            frame_cnt_q  <= frame_cnt_d;
            last_rows_q  <= last_rows_d;
            last_words_q <= last_words_d;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign last_rows  = last_rows_q;
    assign last_words = last_words_q;
    assign row_err    = row_err_q;
    assign col_err    = col_err_q;
    assign frame_ok   = frame_ok_q;
    assign err_sticky = sticky_q;

`ifdef MIPI_FRAME_CHECK_CRC_EN
    logic [15:0] crc_acc_q, crc_acc_d;
    logic [15:0] frame_crc_q, frame_crc_d;

    always_comb begin
        crc_acc_d   = crc_acc_q;
        frame_crc_d = frame_end ? crc_acc_q : frame_crc_q;
        if (!in_active) begin
            crc_acc_d = CRC_INIT;
        end else if (raw_vld && !vs_rise) begin
            crc_acc_d = crc16_next(crc_acc_q, 64'(raw_data), DATA_W);
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            crc_acc_q   <= CRC_INIT;
            frame_crc_q <= '0;
        end else begin
            crc_acc_q   <= crc_acc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    logic data_unused;
    assign data_unused = ^raw_data;
`endif

endmodule

// File: tb/tb_mipi_frame_check.sv
// Scoreboard bench for mipi_frame_check: stimulus pushes expected pulse events, a monitor pops them.
module tb_mipi_frame_check;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int EW = 8;
    localparam int FW = 16;
    localparam int HW = 8;
    localparam int VR = 4;

    logic          sclk = 1'b0;
    logic          s_rst;
    logic          raw_vld;
    logic [DW-1:0] raw_data;
    logic          raw_vsync;
    logic          err_clr;
    logic [FW-1:0] frame_cnt;
    logic [CW-1:0] last_rows;
    logic [CW-1:0] last_words;
    logic          row_err;
    logic          col_err;
    logic          frame_ok;
    logic [EW-1:0] row_err_cnt;
    logic [EW-1:0] col_err_cnt;
    logic          err_sticky;
`ifdef MIPI_FRAME_CHECK_CRC_EN
    logic [15:0]   frame_crc;
`endif

    always #5 sclk = ~sclk;

    mipi_frame_check #(
        .DATA_W  (DW),
        .H_WORDS (HW),
        .V_ROWS  (VR),
        .CNT_W   (CW),
        .ERR_W   (EW),
        .FRM_W   (FW)
    ) dut (
        .sclk        (sclk),
        .s_rst       (s_rst),
        .raw_vld     (raw_vld),
        .raw_data    (raw_data),
        .raw_vsync   (raw_vsync),
        .err_clr     (err_clr),
        .frame_cnt   (frame_cnt),
        .last_rows   (last_rows),
        .last_words  (last_words),
        .row_err     (row_err),
        .col_err     (col_err),
        .frame_ok    (frame_ok),
        .row_err_cnt (row_err_cnt),
        .col_err_cnt (col_err_cnt),
        .err_sticky  (err_sticky)
`ifdef MIPI_FRAME_CHECK_CRC_EN
        ,
        .frame_crc   (frame_crc)
`endif
    );

    typedef struct {
        bit r;
        bit c;
        bit o;
        int rows;
        int words;
        int frames;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_vec = 0;
    int  n_bad = 0;

    // Transaction-level model of what the checker should have seen.
    bit armed;
    bit m_colbad;
    int m_rows, m_lrows, m_lwords, m_frames;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge sclk) begin
        if (!s_rst && (row_err || col_err || frame_ok)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: got row/col/ok=%b%b%b, expected no pulse",
                         row_err, col_err, frame_ok);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_row_err",    32'(row_err),    32'(mon_e.r));
                chk("ev_col_err",    32'(col_err),    32'(mon_e.c));
                chk("ev_frame_ok",   32'(frame_ok),   32'(mon_e.o));
                chk("ev_last_rows",  32'(last_rows),  32'(mon_e.rows));
                chk("ev_last_words", 32'(last_words), 32'(mon_e.words));
                chk("ev_frame_cnt",  32'(frame_cnt),  32'(mon_e.frames));
            end
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input bit r, input bit c, input bit o);
        ev_t e;
        if (r || c || o) begin
            e.r = r; e.c = c; e.o = o;
            e.rows = m_lrows; e.words = m_lwords; e.frames = m_frames;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_frame_end(input bit col_now);
        bit rbad;
        if (armed) begin
            m_frames++;
            m_lrows = m_rows;
            rbad = (m_rows != VR);
            push(rbad, col_now, !rbad && !col_now && !m_colbad);
        end
        armed    = 1'b1;
        m_rows   = 0;
        m_colbad = 1'b0;
    endtask

    task automatic send_row(input int len);
        if (armed) begin
            m_rows++;
            m_lwords = len;
            if (len != HW) begin
                m_colbad = 1'b1;
                push(1'b0, 1'b1, 1'b0);
            end
        end
        for (int i = 0; i < len; i++) begin
            raw_vld  = 1'b1;
            raw_data = DW'(i);
            step();
        end
        raw_vld  = 1'b0;
        raw_data = '0;
        step();
        step();
    endtask

    task automatic send_frame(input int nrows, input int bad_idx, input int bad_len);
        for (int r = 0; r < nrows; r++) send_row((r == bad_idx) ? bad_len : HW);
    endtask

    task automatic vsync(input bit clr);
        model_frame_end(1'b0);
        raw_vld   = 1'b0;
        raw_vsync = 1'b1;
        step();
        err_clr = clr;
        step();
        err_clr   = 1'b0;
        raw_vsync = 1'b0;
        step();
        step();
    endtask

    // Last row still valid when vsync rises: row closes on the vs_rise cycle.
    task automatic row_into_vsync(input int len);
        if (armed) begin
            m_rows++;
            m_lwords = len;
        end
        model_frame_end(armed && (len != HW));
        for (int i = 0; i < len; i++) begin
            raw_vld  = 1'b1;
            raw_data = DW'(i);
            step();
        end
        raw_vsync = 1'b1;
        step();
        raw_vld = 1'b0;
        step();
        raw_vsync = 1'b0;
        step();
        step();
    endtask

    // vld rises together with vsync and stays high into ACTIVE; that run must not count.
    task automatic vsync_with_vld();
        model_frame_end(1'b0);
        raw_vsync = 1'b1;
        raw_vld   = 1'b1;
        step();
        raw_vsync = 1'b0;
        step();
        step();
        step();
        raw_vld = 1'b0;
        step();
        step();
    endtask

    function automatic logic [15:0] ref_crc_rows(input int nrows);
        logic [15:0] c;
        logic [15:0] w;
        logic        fb;
        c = 16'hFFFF;
        for (int r = 0; r < nrows; r++) begin
            for (int i = 0; i < HW; i++) begin
                w = 16'(i);
                for (int b = 0; b < 16; b++) begin
                    fb = c[15] ^ w[15];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                    w = w << 1;
                end
            end
        end
        return c;
    endfunction

    initial begin
        s_rst = 1'b1; raw_vld = 1'b0; raw_data = '0; raw_vsync = 1'b0; err_clr = 1'b0;
        armed = 1'b0; m_colbad = 1'b0;
        m_rows = 0; m_lrows = 0; m_lwords = 0; m_frames = 0;
        step(); step(); step();
        chk("rst_frame_cnt",   32'(frame_cnt),   0);
        chk("rst_last_rows",   32'(last_rows),   0);
        chk("rst_last_words",  32'(last_words),  0);
        chk("rst_pulses",      32'({row_err, col_err, frame_ok}), 0);
        chk("rst_row_err_cnt", 32'(row_err_cnt), 0);
        chk("rst_col_err_cnt", 32'(col_err_cnt), 0);
        chk("rst_sticky",      32'(err_sticky),  0);
        s_rst = 1'b0;
        step();

        // Partial frame after reset is never checked; then one good frame.
        send_frame(2, -1, 0);
        vsync(1'b0);
        send_frame(4, -1, 0);
        vsync(1'b0);
        step(); step();
        chk("t1_row_err_cnt", 32'(row_err_cnt), 0);
        chk("t1_col_err_cnt", 32'(col_err_cnt), 0);

        // Short row in the middle of a frame.
        send_frame(4, 2, 7);
        vsync(1'b0);
        step(); step();
        chk("t2_col_err_cnt", 32'(col_err_cnt), 1);
        chk("t2_sticky",      32'(err_sticky),  1);
        chk("t2_frame_cnt",   32'(frame_cnt),   2);

        // Too many rows.
        send_frame(5, -1, 0);
        vsync(1'b0);
        step(); step();
        chk("t3_row_err_cnt", 32'(row_err_cnt), 1);

        // Saturation, then clear coinciding with a row_err pulse.
        for (int f = 0; f < 300; f++) begin
            send_frame(3, -1, 0);
            vsync(1'b0);
        end
        step(); step();
        chk("t4_row_err_sat", 32'(row_err_cnt), 255);
        chk("t4_col_err_cnt", 32'(col_err_cnt), 1);
        send_frame(3, -1, 0);
        vsync(1'b1);
        chk("t4_clr_row_cnt", 32'(row_err_cnt), 0);
        chk("t4_clr_col_cnt", 32'(col_err_cnt), 0);
        chk("t4_clr_sticky",  32'(err_sticky),  0);

        // vld held into vs_rise, then vld_rise coincident with vs_rise.
        send_frame(3, -1, 0);
        row_into_vsync(HW);
        send_frame(4, -1, 0);
        vsync_with_vld();
        send_frame(4, -1, 0);
        vsync(1'b0);
        step(); step();
        chk("t5_col_err_cnt", 32'(col_err_cnt), 0);
        chk("t5_row_err_cnt", 32'(row_err_cnt), 0);
        chk("t5_sticky",      32'(err_sticky),  0);

        // Reset mid-frame discards that frame; then a CRC frame.
        send_frame(2, -1, 0);
        chk("t6_queue_before_rst", 32'(exp_q.size()), 0);
        s_rst = 1'b1;
        step(); step();
        s_rst = 1'b0;
        armed = 1'b0; m_colbad = 1'b0;
        m_rows = 0; m_lrows = 0; m_lwords = 0; m_frames = 0;
        step();
        chk("t6_rst_frame_cnt", 32'(frame_cnt), 0);
        send_frame(1, -1, 0);
        vsync(1'b0);
`ifdef MIPI_FRAME_CHECK_CRC_EN
        chk("t6_crc_after_rst", 32'(frame_crc), 0);
`endif
        send_frame(4, -1, 0);
        vsync(1'b0);
`ifdef MIPI_FRAME_CHECK_CRC_EN
        chk("t6_frame_crc", 32'(frame_crc), 32'(ref_crc_rows(4)));
`endif
        chk("t6_frame_cnt", 32'(frame_cnt), 1);

        step(); step(); step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
